// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
// The optional burst mode is enabled by defining FIFO_ARB_BURST_EN.
package fifo_arb_pkg;
  typedef enum logic {IDLE, WRITE} arb_state_e;
  localparam int DEF_NREQ   = 2;
  localparam int DEF_DWIDTH = 8;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping at NREQ-1.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic [NREQ-1:0]         gnt_onehot,
  output logic [$clog2(NREQ)-1:0] gnt_idx,
  output logic                    any
);
  localparam int IW = $clog2(NREQ);

  int j;

  // Wrap is done on the integer index so non-power-of-2 NREQ never lands past NREQ-1.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    j          = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = int'(last) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!any && req[j]) begin
        any           = 1'b1;
        gnt_idx       = IW'(j);
        gnt_onehot[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NREQ producers.
// Define FIFO_ARB_BURST_EN to let a granted requester keep the port for up to BURST_LEN writes.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ   = DEF_NREQ,
  parameter int DWIDTH = DEF_DWIDTH
`ifdef FIFO_ARB_BURST_EN
  , parameter int BURST_LEN = 4
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DWIDTH-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_wr,
  output logic [DWIDTH-1:0]        fifo_wdata,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output arb_state_e               state_dbg
);
  // Handshake: requester i transfers in the cycle where req_valid[i] & req_ready[i];
  // req_data must stay stable while req_valid is high, and dropping valid before ready is legal.
  localparam int IW = $clog2(NREQ);

  arb_state_e      state, state_nxt;
  logic [IW-1:0]   last_grant;
  logic [NREQ-1:0] rr_onehot, win_onehot;
  logic [IW-1:0]   rr_idx, win_idx;
  logic            rr_any, win_any, capture;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req        (req_valid),
    .last       (last_grant),
    .gnt_onehot (rr_onehot),
    .gnt_idx    (rr_idx),
    .any        (rr_any)
  );

`ifdef FIFO_ARB_BURST_EN
  localparam int BW = $clog2(BURST_LEN) + 1;

  logic [BW-1:0] burst_cnt;
  logic          burst_own;
  logic          burst_hold;

  // burst_own keeps the reset value of last_grant from counting as a real previous grant.
  assign burst_hold = burst_own & req_valid[last_grant] & (burst_cnt < BW'(BURST_LEN - 1));

  always_comb begin
    win_onehot = rr_onehot;
    win_idx    = rr_idx;
    win_any    = rr_any;
    if (burst_hold) begin
      win_onehot             = '0;
      win_onehot[last_grant] = 1'b1;
      win_idx                = last_grant;
      win_any                = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_cnt <= '0;
      burst_own <= 1'b0;
    end else if (capture) begin
      burst_own <= 1'b1;
      burst_cnt <= burst_hold ? burst_cnt + BW'(1) : '0;
    end
  end
`else
  assign win_onehot = rr_onehot;
  assign win_idx    = rr_idx;
  assign win_any    = rr_any;
`endif

  assign capture   = (state == IDLE) & win_any & ~fifo_full;
  assign req_ready = {NREQ{(state == IDLE) & ~fifo_full & ~rst}} & win_onehot;
  assign state_dbg = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (capture) state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // fifo_wr is high exactly while in WRITE; the gap cycle lets fifo_full settle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_wr    <= 1'b0;
      fifo_wdata <= '0;
      grant_id   <= '0;
      last_grant <= IW'(NREQ - 1);
    end else begin
      fifo_wr <= capture;
      if (capture) begin
        fifo_wdata <= req_data[win_idx*DWIDTH +: DWIDTH];
        grant_id   <= win_idx;
        last_grant <= win_idx;
      end
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NREQ=2 and NREQ=3 instances) with scoreboard monitors.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int W = 10;  // {grant_id[1:0], data[7:0]}

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  v2;   logic [15:0] d2;  logic [1:0] rdy2; logic full2;
  logic        wr2;  logic [7:0]  wd2; logic [0:0] gid2; arb_state_e st2;
  logic [2:0]  v3;   logic [23:0] d3;  logic [2:0] rdy3; logic full3;
  logic        wr3;  logic [7:0]  wd3; logic [1:0] gid3; arb_state_e st3;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp3_q[$];
  logic [W-1:0] e2, e3;
  int n_checks = 0;
  int n_fail   = 0;

  fifo_wr_arbiter #(.NREQ(2), .DWIDTH(8)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid(v2), .req_data(d2), .req_ready(rdy2),
    .fifo_full(full2), .fifo_wr(wr2), .fifo_wdata(wd2), .grant_id(gid2), .state_dbg(st2)
  );

  fifo_wr_arbiter #(.NREQ(3), .DWIDTH(8)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(v3), .req_data(d3), .req_ready(rdy3),
    .fifo_full(full3), .fifo_wr(wr3), .fifo_wdata(wd3), .grant_id(gid3), .state_dbg(st3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: every write strobe must match the next expected entry.
  always @(negedge clk) begin
    if (wr2 === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL wr2_unexpected: got write 0x%0h, expected none", {gid2, wd2});
      end else begin
        e2 = exp_q.pop_front();
        check("wr2_id_data", 32'({1'b0, gid2, wd2}), 32'(e2));
      end
    end
  end

  always @(negedge clk) begin
    if (wr3 === 1'b1) begin
      if (exp3_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL wr3_unexpected: got write 0x%0h, expected none", {gid3, wd3});
      end else begin
        e3 = exp3_q.pop_front();
        check("wr3_id_data", 32'({gid3, wd3}), 32'(e3));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    v2 = '0; d2 = '0; full2 = 1'b0;
    v3 = '0; d3 = '0; full3 = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push2(input logic [1:0] id, input logic [7:0] d);
    exp_q.push_back({id, d});
  endtask

  task automatic push3(input logic [1:0] id, input logic [7:0] d);
    exp3_q.push_back({id, d});
  endtask

  initial begin
    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_fifo_wr", 32'(wr2), 32'(0));
    check("rst_fifo_wdata", 32'(wd2), 32'(0));
    check("rst_grant_id", 32'(gid2), 32'(0));
    check("rst_state", 32'(st2), 32'(IDLE));
    check("rst_req_ready", 32'(rdy2), 32'(0));

    // Single request, same-cycle ready, write one cycle later
    tick();
    v2 = 2'b01; d2 = 16'h00A5;
    @(negedge clk);
    check("t1_req_ready", 32'(rdy2), 32'(2'b01));
    push2(2'd0, 8'hA5);
    tick();
    v2 = 2'b00;
    check("t1_state_write", 32'(st2), 32'(WRITE));
    repeat (3) tick();

`ifndef FIFO_ARB_BURST_EN
    // Both valid: alternate grants every second cycle
    do_reset();
    v2 = 2'b11; d2 = 16'h2211;
    push2(2'd0, 8'h11); push2(2'd1, 8'h22); push2(2'd0, 8'h11); push2(2'd1, 8'h22);
    @(negedge clk);
    check("t2_ready_first", 32'(rdy2), 32'(2'b01));
    tick();
    @(negedge clk);
    check("t2_ready_in_write", 32'(rdy2), 32'(2'b00));
    repeat (6) tick();
    v2 = 2'b00;
    repeat (3) tick();
`else
    // Burst: four writes from req0 then four from req1
    do_reset();
    v2 = 2'b11; d2 = 16'h2211;
    for (int i = 0; i < 4; i++) push2(2'd0, 8'h11);
    for (int i = 0; i < 4; i++) push2(2'd1, 8'h22);
    repeat (15) tick();
    v2 = 2'b00;
    repeat (3) tick();
    // Burst cut short: req0 drops valid after two grants
    do_reset();
    v2 = 2'b11; d2 = 16'h2211;
    push2(2'd0, 8'h11); push2(2'd0, 8'h11); push2(2'd1, 8'h22);
    repeat (3) tick();
    v2 = 2'b10;
    repeat (2) tick();
    v2 = 2'b00;
    repeat (3) tick();
`endif

    // FIFO full blocks every grant; release resumes with req0
    do_reset();
    full2 = 1'b1; v2 = 2'b11; d2 = 16'h2211;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_ready_full", 32'(rdy2), 32'(0));
      check("t3_state_full", 32'(st2), 32'(IDLE));
    end
    tick();
    full2 = 1'b0;
    push2(2'd0, 8'h11);
`ifndef FIFO_ARB_BURST_EN
    push2(2'd1, 8'h22);
`else
    push2(2'd0, 8'h11);
`endif
    @(negedge clk);
    check("t3_ready_release", 32'(rdy2), 32'(2'b01));
    repeat (3) tick();
    v2 = 2'b00;
    repeat (3) tick();

    // Reset during WRITE: strobe drops asynchronously, byte discarded
    do_reset();
    v2 = 2'b10; d2 = 16'h2200;
    tick();
    v2 = 2'b00;
    check("t4_wr_before_rst", 32'(wr2), 32'(1));
    rst = 1'b1;
    #1;
    check("t4_wr_async_drop", 32'(wr2), 32'(0));
    check("t4_state_async", 32'(st2), 32'(IDLE));
    tick();
    rst = 1'b0;
    v2 = 2'b11; d2 = 16'h4433;
    @(negedge clk);
    check("t4_ready_after_rst", 32'(rdy2), 32'(2'b01));
    push2(2'd0, 8'h33);
`ifndef FIFO_ARB_BURST_EN
    push2(2'd1, 8'h44);
`else
    push2(2'd0, 8'h33);
`endif
    repeat (3) tick();
    v2 = 2'b00;
    repeat (3) tick();

    // NREQ=3 with req0 and req2: pointer wraps 2 -> 0
    do_reset();
    v3 = 3'b101; d3 = 24'hC3005A;
    @(negedge clk);
    check("t6_ready_first", 32'(rdy3), 32'(3'b001));
`ifndef FIFO_ARB_BURST_EN
    push3(2'd0, 8'h5A); push3(2'd2, 8'hC3); push3(2'd0, 8'h5A); push3(2'd2, 8'hC3);
`else
    for (int i = 0; i < 4; i++) push3(2'd0, 8'h5A);
`endif
    repeat (7) tick();
    v3 = 3'b000;
    repeat (3) tick();
    check("t6_grant_id_last", 32'(gid3),
`ifndef FIFO_ARB_BURST_EN
          32'(2));
`else
          32'(0));
`endif

    check("q2_drained", 32'(exp_q.size()), 32'(0));
    check("q3_drained", 32'(exp3_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
